// File: rtl/led_matrix_scan_ctrl.sv
// Scan scheduler for two 8x8 LED panels (X and Y) sharing one row bus.
// Keeps a double-buffered frame image and swaps shadow into active only at a
// frame boundary, so a frame is always drawn from one consistent image.
// Every slot is a blanking gap followed by a dwell that drives one column.
module led_matrix_scan_ctrl #(
  parameter int BLANK_CYCLES = 16,
  parameter int DWELL_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic       wr_panel,
  input  logic [2:0] wr_col,
  input  logic [7:0] wr_data,
  input  logic       commit,
  output logic       commit_pending,
  output logic       frame_start,
  output logic       scan_panel,
  output logic [2:0] scan_col,
  output logic [7:0] row,
  output logic [7:0] colx,
  output logic [7:0] coly
);

  // The timer only has to hold the longer of the two phase lengths minus one.
  localparam int TMAX = (BLANK_CYCLES > DWELL_CYCLES) ? BLANK_CYCLES : DWELL_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  state_t          state;
  logic            run;        // 0 while held at slot 0 by reset or enable low
  logic [3:0]      slot;       // slot[0] = panel, slot[3:1] = column
  logic [TW-1:0]   timer;

  logic [7:0]      active [2][8];
  logic [7:0]      shadow [2][8];

  logic            blank_done;
  logic            drive_done;
  logic            frame_end;
  logic            swap;
  logic            wr_accept;
  logic [7:0]      col_onehot;

  assign blank_done = (state == ST_BLANK) && (timer == TW'(BLANK_CYCLES - 1));
  assign drive_done = (state == ST_DRIVE) && (timer == TW'(DWELL_CYCLES - 1));

  // Only the edge that closes the dwell of slot 15 is a frame boundary.
  assign frame_end  = run && enable && drive_done && (slot == 4'd15);

  // While held the display is dark, so a pending swap can be taken at once.
  assign swap       = commit_pending && (frame_end || !run);

  assign wr_ready   = ~commit_pending;
  assign wr_accept  = wr_valid && !commit_pending;

  assign col_onehot = 8'd1 << slot[3:1];
  assign scan_panel = slot[0];
  assign scan_col   = slot[3:1];

  // Slot sequencer with registered row/column drive and frame marker.
  always_ff @(posedge clk) begin
    if (!reset || !enable) begin
      run         <= 1'b0;
      state       <= ST_BLANK;
      slot        <= 4'd0;
      timer       <= '0;
      row         <= 8'hFF;
      colx        <= 8'h00;
      coly        <= 8'h00;
      frame_start <= 1'b0;
    end else if (!run) begin
      // First running edge: open slot 0 blanking and mark the frame.
      run         <= 1'b1;
      state       <= ST_BLANK;
      slot        <= 4'd0;
      timer       <= '0;
      row         <= 8'hFF;
      colx        <= 8'h00;
      coly        <= 8'h00;
      frame_start <= 1'b1;
    end else begin
      frame_start <= 1'b0;
      case (state)
        ST_BLANK: begin
          if (blank_done) begin
            state <= ST_DRIVE;
            timer <= '0;
            row   <= active[slot[0]][slot[3:1]];
            colx  <= slot[0] ? 8'h00 : col_onehot;
            coly  <= slot[0] ? col_onehot : 8'h00;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        ST_DRIVE: begin
          if (drive_done) begin
            state       <= ST_BLANK;
            timer       <= '0;
            slot        <= slot + 4'd1;
            row         <= 8'hFF;
            colx        <= 8'h00;
            coly        <= 8'h00;
            frame_start <= (slot == 4'd15);
          end else begin
            timer <= timer + TW'(1);
          end
        end
        default: begin
          state <= ST_BLANK;
          timer <= '0;
        end
      endcase
    end
  end

  // Commit handshake: latch a request, release it when the swap happens.
  always_ff @(posedge clk) begin
    if (!reset) begin
      commit_pending <= 1'b0;
    end else if (swap) begin
      commit_pending <= 1'b0;
    end else if (commit) begin
      commit_pending <= 1'b1;
    end
  end

  // Frame image storage: shadow takes writes, active is loaded on swap.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int p = 0; p < 2; p++) begin
        for (int c = 0; c < 8; c++) begin
          active[p][c] <= 8'hFF;
          shadow[p][c] <= 8'hFF;
        end
      end
    end else begin
      if (wr_accept) begin
        shadow[wr_panel][wr_col] <= wr_data;
      end
      if (swap) begin
        for (int p = 0; p < 2; p++) begin
          for (int c = 0; c < 8; c++) begin
            active[p][c] <= shadow[p][c];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_led_matrix_scan_ctrl.sv
// Scoreboard bench for led_matrix_scan_ctrl with a 5-cycle slot / 80-cycle frame.
// The stimulus process queues (cycle, signal, value) expectations; a monitor
// process compares every queued entry when the DUT reaches that cycle.
module tb_led_matrix_scan_ctrl;

  localparam int F_ROW  = 0;
  localparam int F_COLX = 1;
  localparam int F_COLY = 2;
  localparam int F_FS   = 3;
  localparam int F_PEND = 4;
  localparam int F_RDY  = 5;
  localparam int F_SCOL = 6;
  localparam int F_SPAN = 7;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       wr_valid;
  logic       wr_ready;
  logic       wr_panel;
  logic [2:0] wr_col;
  logic [7:0] wr_data;
  logic       commit;
  logic       commit_pending;
  logic       frame_start;
  logic       scan_panel;
  logic [2:0] scan_col;
  logic [7:0] row;
  logic [7:0] colx;
  logic [7:0] coly;

  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         overlap = 0;
  logic       done_req = 1'b0;
  logic       done_ack = 1'b0;

  int         q_cyc [$];
  int         q_fld [$];
  logic [7:0] q_val [$];
  string      q_name [$];

  led_matrix_scan_ctrl #(
    .BLANK_CYCLES(1),
    .DWELL_CYCLES(4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .wr_panel       (wr_panel),
    .wr_col         (wr_col),
    .wr_data        (wr_data),
    .commit         (commit),
    .commit_pending (commit_pending),
    .frame_start    (frame_start),
    .scan_panel     (scan_panel),
    .scan_col       (scan_col),
    .row            (row),
    .colx           (colx),
    .coly           (coly)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle label: value after a posedge names the cycle that edge opens.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] actual(input int f);
    case (f)
      F_ROW:   return row;
      F_COLX:  return colx;
      F_COLY:  return coly;
      F_FS:    return {7'd0, frame_start};
      F_PEND:  return {7'd0, commit_pending};
      F_RDY:   return {7'd0, wr_ready};
      F_SCOL:  return {5'd0, scan_col};
      default: return {7'd0, scan_panel};
    endcase
  endfunction

  task automatic ex(input int c, input int f, input logic [7:0] v, input string n);
    q_cyc.push_back(c);
    q_fld.push_back(f);
    q_val.push_back(v);
    q_name.push_back(n);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: compare due expectations every cycle, away from the active edge.
  initial begin
    logic [7:0] act;
    forever begin
      @(negedge clk);
      for (int i = q_cyc.size() - 1; i >= 0; i--) begin
        if (q_cyc[i] == cyc) begin
          act = actual(q_fld[i]);
          checks++;
          if (act !== q_val[i]) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", q_name[i], cyc, act, q_val[i]);
          end
          q_cyc.delete(i);
          q_fld.delete(i);
          q_val.delete(i);
          q_name.delete(i);
        end
      end
      if (colx != 8'h00 && coly != 8'h00) overlap++;
      if (done_req && !done_ack) begin
        checks++;
        if (overlap != 0) begin
          errors++;
          $display("FAIL col_overlap: got %0d cycles with colx and coly both set, expected 0", overlap);
        end
        checks++;
        if (q_cyc.size() != 0) begin
          errors++;
          $display("FAIL unreached_expectations: got %0d left, expected 0", q_cyc.size());
        end
        done_ack = 1'b1;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b;
    int b2;
    int b3;
    reset    = 1'b0;
    enable   = 1'b0;
    wr_valid = 1'b0;
    wr_panel = 1'b0;
    wr_col   = 3'd0;
    wr_data  = 8'h00;
    commit   = 1'b0;

    // Reset state, with a commit and a write attempted under reset.
    for (int c = 2; c <= 3; c++) begin
      ex(c, F_ROW,  8'hFF, "rst_row");
      ex(c, F_COLX, 8'h00, "rst_colx");
      ex(c, F_COLY, 8'h00, "rst_coly");
      ex(c, F_RDY,  8'h01, "rst_ready");
      ex(c, F_PEND, 8'h00, "rst_pending");
      ex(c, F_FS,   8'h00, "rst_frame_start");
    end
    wait_until(1);
    commit   = 1'b1;
    wr_valid = 1'b1;
    wait_until(3);
    commit   = 1'b0;
    wr_valid = 1'b0;

    // Test 1: scan order and frame period.
    wait_until(5);
    b = cyc + 1;
    ex(b,      F_FS,   8'h01, "t1_fs_c0");
    ex(b,      F_ROW,  8'hFF, "t1_row_c0");
    ex(b,      F_COLX, 8'h00, "t1_colx_c0");
    ex(b,      F_COLY, 8'h00, "t1_coly_c0");
    ex(b,      F_SCOL, 8'h00, "t1_scol_c0");
    ex(b + 1,  F_FS,   8'h00, "t1_fs_c1");
    ex(b + 1,  F_COLX, 8'h01, "t1_colx_c1");
    ex(b + 1,  F_ROW,  8'hFF, "t1_row_x0_unwritten");
    ex(b + 4,  F_COLX, 8'h01, "t1_colx_c4");
    ex(b + 5,  F_COLX, 8'h00, "t1_colx_c5");
    ex(b + 6,  F_COLY, 8'h01, "t1_coly_c6");
    ex(b + 6,  F_COLX, 8'h00, "t1_colx_c6");
    ex(b + 6,  F_SPAN, 8'h01, "t1_span_c6");
    ex(b + 9,  F_COLY, 8'h01, "t1_coly_c9");
    ex(b + 11, F_COLX, 8'h02, "t1_colx_c11");
    ex(b + 11, F_SCOL, 8'h01, "t1_scol_c11");
    ex(b + 79, F_FS,   8'h00, "t1_fs_c79");
    ex(b + 80, F_FS,   8'h01, "t1_fs_c80");
    reset  = 1'b1;
    enable = 1'b1;

    // Test 2: write X3=E7, commit; visible only in the next frame.
    ex(b + 3,   F_PEND, 8'h00, "t2_pend_before");
    ex(b + 4,   F_PEND, 8'h01, "t2_pend_set");
    ex(b + 4,   F_RDY,  8'h00, "t2_ready_low");
    ex(b + 31,  F_ROW,  8'hFF, "t2_row_same_frame");
    ex(b + 31,  F_COLX, 8'h08, "t2_colx_same_frame");
    ex(b + 79,  F_PEND, 8'h01, "t2_pend_last");
    ex(b + 80,  F_PEND, 8'h00, "t2_pend_clear");
    ex(b + 110, F_ROW,  8'hFF, "t2_row_blank");
    ex(b + 111, F_ROW,  8'hE7, "t2_row_next_frame");
    ex(b + 111, F_COLX, 8'h08, "t2_colx_next_frame");
    wait_until(b + 2);
    wr_valid = 1'b1;
    wr_panel = 1'b0;
    wr_col   = 3'd3;
    wr_data  = 8'hE7;
    wait_until(b + 3);
    wr_valid = 1'b0;
    commit   = 1'b1;
    wait_until(b + 4);
    commit   = 1'b0;

    // Test 3: commit in the last cycle of slot 15, write held meanwhile.
    ex(b + 159, F_PEND, 8'h00, "t3_pend_before");
    ex(b + 160, F_PEND, 8'h01, "t3_pend_set");
    ex(b + 160, F_FS,   8'h01, "t3_fs_frame2");
    ex(b + 160, F_RDY,  8'h00, "t3_ready_low_start");
    ex(b + 200, F_PEND, 8'h01, "t3_pend_mid");
    ex(b + 239, F_PEND, 8'h01, "t3_pend_last");
    ex(b + 239, F_RDY,  8'h00, "t3_ready_low_end");
    ex(b + 240, F_PEND, 8'h00, "t3_pend_clear");
    ex(b + 240, F_RDY,  8'h01, "t3_ready_high");
    ex(b + 240, F_FS,   8'h01, "t3_fs_frame3");
    ex(b + 241, F_ROW,  8'hFF, "t3_x0_not_written");
    ex(b + 241, F_COLX, 8'h01, "t3_colx_x0");
    ex(b + 271, F_ROW,  8'hE7, "t3_x3_kept");
    wait_until(b + 159);
    commit = 1'b1;
    wait_until(b + 160);
    commit = 1'b0;
    wait_until(b + 169);
    wr_valid = 1'b1;
    wr_panel = 1'b0;
    wr_col   = 3'd0;
    wr_data  = 8'h00;
    wait_until(b + 239);
    wr_valid = 1'b0;

    // Test 4: write+commit together, then a stalled back-to-back write.
    ex(b + 250, F_PEND, 8'h01, "t4_pend_set");
    ex(b + 250, F_RDY,  8'h00, "t4_ready_stall");
    ex(b + 266, F_ROW,  8'hFF, "t4_y2_old");
    ex(b + 266, F_COLY, 8'h04, "t4_coly_y2");
    ex(b + 319, F_RDY,  8'h00, "t4_ready_stall_end");
    ex(b + 320, F_PEND, 8'h00, "t4_pend_clear");
    ex(b + 320, F_RDY,  8'h01, "t4_ready_high");
    ex(b + 346, F_ROW,  8'h5A, "t4_y2_new");
    ex(b + 346, F_COLY, 8'h04, "t4_coly_y2_new");
    ex(b + 346, F_COLX, 8'h00, "t4_colx_zero_y2");
    ex(b + 351, F_ROW,  8'hE7, "t4_x3_still");
    ex(b + 371, F_ROW,  8'hFF, "t4_x5_uncommitted");
    ex(b + 371, F_COLX, 8'h20, "t4_colx_x5");
    ex(b + 331, F_PEND, 8'h01, "t4_pend_second");
    ex(b + 400, F_PEND, 8'h00, "t4_pend_second_clear");
    ex(b + 426, F_ROW,  8'h5A, "t4_y2_frame5");
    ex(b + 451, F_ROW,  8'h3C, "t4_x5_committed");
    ex(b + 451, F_COLX, 8'h20, "t4_colx_x5_committed");
    wait_until(b + 249);
    wr_valid = 1'b1;
    wr_panel = 1'b1;
    wr_col   = 3'd2;
    wr_data  = 8'h5A;
    commit   = 1'b1;
    wait_until(b + 250);
    commit   = 1'b0;
    wr_panel = 1'b0;
    wr_col   = 3'd5;
    wr_data  = 8'h3C;
    wait_until(b + 321);
    wr_valid = 1'b0;
    wait_until(b + 330);
    commit = 1'b1;
    wait_until(b + 331);
    commit = 1'b0;

    // Test 5: drop enable mid-slot 5 with a commit pending.
    ex(b + 490, F_PEND, 8'h01, "t5_pend_set");
    ex(b + 507, F_COLY, 8'h04, "t5_coly_before");
    ex(b + 507, F_ROW,  8'h5A, "t5_row_before");
    ex(b + 507, F_SCOL, 8'h02, "t5_scol_before");
    ex(b + 507, F_SPAN, 8'h01, "t5_span_before");
    ex(b + 508, F_COLX, 8'h00, "t5_colx_off");
    ex(b + 508, F_COLY, 8'h00, "t5_coly_off");
    ex(b + 508, F_ROW,  8'hFF, "t5_row_off");
    ex(b + 508, F_SCOL, 8'h00, "t5_scol_zero");
    ex(b + 508, F_SPAN, 8'h00, "t5_span_zero");
    ex(b + 508, F_PEND, 8'h01, "t5_pend_held");
    ex(b + 509, F_PEND, 8'h00, "t5_pend_clear");
    ex(b + 510, F_FS,   8'h00, "t5_fs_disabled");
    ex(b + 515, F_FS,   8'h01, "t5_fs_restart");
    ex(b + 516, F_ROW,  8'h81, "t5_x0_new");
    ex(b + 516, F_COLX, 8'h01, "t5_colx_x0");
    wait_until(b + 484);
    wr_valid = 1'b1;
    wr_panel = 1'b0;
    wr_col   = 3'd0;
    wr_data  = 8'h81;
    wait_until(b + 485);
    wr_valid = 1'b0;
    wait_until(b + 489);
    commit = 1'b1;
    wait_until(b + 490);
    commit = 1'b0;
    wait_until(b + 507);
    enable = 1'b0;
    wait_until(b + 514);
    enable = 1'b1;

    // Test 6: reset during DRIVE of X1 with a commit pending.
    b2 = b + 515;
    b3 = b2 + 14;
    ex(b2 + 6,  F_PEND, 8'h01, "t6_pend_set");
    ex(b2 + 11, F_COLX, 8'h02, "t6_colx_x1");
    ex(b2 + 12, F_COLX, 8'h00, "t6_colx_reset");
    ex(b2 + 12, F_ROW,  8'hFF, "t6_row_reset");
    ex(b2 + 12, F_PEND, 8'h00, "t6_pend_reset");
    ex(b2 + 12, F_RDY,  8'h01, "t6_ready_reset");
    ex(b2 + 12, F_FS,   8'h00, "t6_fs_reset");
    ex(b3,      F_FS,   8'h01, "t6_fs_restart");
    ex(b3 + 1,  F_ROW,  8'hFF, "t6_x0_cleared");
    ex(b3 + 1,  F_COLX, 8'h01, "t6_colx_x0");
    ex(b3 + 26, F_ROW,  8'hFF, "t6_y2_cleared");
    ex(b3 + 26, F_COLY, 8'h04, "t6_coly_y2");
    ex(b3 + 31, F_ROW,  8'hFF, "t6_x3_cleared");
    wait_until(b2 + 5);
    commit = 1'b1;
    wait_until(b2 + 6);
    commit = 1'b0;
    wait_until(b2 + 11);
    reset = 1'b0;
    wait_until(b2 + 13);
    reset = 1'b1;

    // Random write/commit run; the monitor tracks column-bus overlap.
    wait_until(b3 + 35);
    for (int k = 0; k < 400; k++) begin
      wr_valid = 1'($urandom_range(0, 1));
      wr_panel = 1'($urandom_range(0, 1));
      wr_col   = 3'($urandom_range(0, 7));
      wr_data  = 8'($urandom);
      commit   = ($urandom_range(0, 15) == 0);
      @(negedge clk);
    end
    wr_valid = 1'b0;
    commit   = 1'b0;
    repeat (5) @(negedge clk);

    done_req = 1'b1;
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
